// File: rtl/controle_tempo_jogada_pkg.sv
// Shared definitions for the per-turn timer: state encoding and the
// debug code shown on the hexa7seg display.
package controle_tempo_jogada_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        ALERTA   = 2'd2,
        ESGOTADO = 2'd3
    } estado_t;

    // Debug nibble is the state code zero-extended, so unidade_controle
    // can decode it with the same table.
    function automatic logic [3:0] codigo_db(input estado_t estado);
        return {2'b00, estado};
    endfunction

endpackage

// File: rtl/controle_tempo_jogada_contador_prescaler.sv
// Divides clock down to a one-second tick. The tick is asserted during
// the last prescaler cycle so the FSM sees it on the same edge as the wrap.
module contador_prescaler #(
    parameter int CICLOS_SEG = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic tick
);

    localparam int W = $clog2(CICLOS_SEG + 1);

    logic [W-1:0] cnt_q;

    assign tick = conta && (cnt_q == W'(CICLOS_SEG - 1));

    // Prescaler counter: clear has priority over counting, wraps on tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (zera) begin
            cnt_q <= '0;
        end else if (conta) begin
            if (tick) cnt_q <= '0;
            else      cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/controle_tempo_jogada.sv
// Per-turn countdown timer for the tic-tac-toe controller.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   OCIOSO   | idle, waiting for iniciar_vez; seg frozen
//   CONTANDO | counting whole seconds, above the warning level
//   ALERTA   | counting, at or below the warning level
//   ESGOTADO | time ran out; one-cycle tempo_esgotado, then OCIOSO
module controle_tempo_jogada
    import controle_tempo_jogada_pkg::*;
#(
    parameter int CICLOS_SEG   = 50000000,
    parameter int TEMPO_VEZ    = 30,
    parameter int TEMPO_ALERTA = 5,
    parameter int LARGURA_SEG  = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar_vez,
    input  logic                   jogada_feita,
    input  logic                   pausar,
    input  logic                   cancelar,
    output logic                   contando,
    output logic                   alerta,
    output logic                   tempo_esgotado,
    output logic [LARGURA_SEG-1:0] segundos_restantes,
    output logic [3:0]             db_estado
);

    localparam logic [LARGURA_SEG-1:0] SEG_INI    = LARGURA_SEG'(TEMPO_VEZ);
    localparam logic [LARGURA_SEG-1:0] SEG_ALERTA = LARGURA_SEG'(TEMPO_ALERTA);
    // A turn shorter than the warning window starts directly in ALERTA.
    localparam bit      ALERTA_INI = (TEMPO_ALERTA != 0) && (TEMPO_VEZ <= TEMPO_ALERTA);
    localparam estado_t ESTADO_INI = ALERTA_INI ? ALERTA : CONTANDO;

    estado_t                estado_q;
    logic [LARGURA_SEG-1:0] seg_q;
    logic [LARGURA_SEG-1:0] seg_menos_d;
    logic                   contando_q;
    logic                   alerta_q;
    logic                   esgotado_q;
    logic                   ativo;
    logic                   tick;

    assign ativo       = (estado_q == CONTANDO) || (estado_q == ALERTA);
    // Saturating decrement: the seconds counter never wraps below zero.
    assign seg_menos_d = (seg_q == '0) ? '0 : seg_q - 1'b1;

    contador_prescaler #(
        .CICLOS_SEG(CICLOS_SEG)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .zera  (cancelar || jogada_feita || iniciar_vez),
        .conta (ativo && !pausar),
        .tick  (tick)
    );

    // Turn FSM, seconds register and registered status flags.
    // Priority: cancelar > jogada_feita > iniciar_vez > tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            seg_q      <= SEG_INI;
            contando_q <= 1'b0;
            alerta_q   <= 1'b0;
            esgotado_q <= 1'b0;
        end else begin
            esgotado_q <= 1'b0;
            if (cancelar) begin
                estado_q   <= OCIOSO;
                seg_q      <= SEG_INI;
                contando_q <= 1'b0;
                alerta_q   <= 1'b0;
            end else begin
                case (estado_q)
                    OCIOSO: begin
                        if (iniciar_vez) begin
                            estado_q   <= ESTADO_INI;
                            seg_q      <= SEG_INI;
                            contando_q <= !pausar;
                            alerta_q   <= ALERTA_INI;
                        end
                    end
                    CONTANDO, ALERTA: begin
                        if (jogada_feita) begin
                            estado_q   <= OCIOSO;
                            contando_q <= 1'b0;
                            alerta_q   <= 1'b0;
                        end else if (iniciar_vez) begin
                            estado_q   <= ESTADO_INI;
                            seg_q      <= SEG_INI;
                            contando_q <= !pausar;
                            alerta_q   <= ALERTA_INI;
                        end else begin
                            contando_q <= !pausar;
                            if (tick) begin
                                seg_q <= seg_menos_d;
                                if (seg_menos_d == '0) begin
                                    estado_q   <= ESGOTADO;
                                    esgotado_q <= 1'b1;
                                    contando_q <= 1'b0;
                                    alerta_q   <= 1'b0;
                                end else if (estado_q == CONTANDO && seg_menos_d == SEG_ALERTA) begin
                                    estado_q <= ALERTA;
                                    alerta_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ESGOTADO: begin
                        estado_q   <= OCIOSO;
                        contando_q <= 1'b0;
                        alerta_q   <= 1'b0;
                    end
                    default: begin
                        estado_q   <= OCIOSO;
                        contando_q <= 1'b0;
                        alerta_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign contando           = contando_q;
    assign alerta             = alerta_q;
    assign tempo_esgotado     = esgotado_q;
    assign segundos_restantes = seg_q;
    assign db_estado          = codigo_db(estado_q);

endmodule

// File: tb/tb_controle_tempo_jogada.sv
// Bench for controle_tempo_jogada with CICLOS_SEG=4, TEMPO_VEZ=3, TEMPO_ALERTA=1.
module tb_controle_tempo_jogada;

    logic       clock;
    logic       reset;
    logic       iniciar_vez;
    logic       jogada_feita;
    logic       pausar;
    logic       cancelar;
    logic       contando;
    logic       alerta;
    logic       tempo_esgotado;
    logic [5:0] segundos_restantes;
    logic [3:0] db_estado;

    controle_tempo_jogada #(
        .CICLOS_SEG  (4),
        .TEMPO_VEZ   (3),
        .TEMPO_ALERTA(1),
        .LARGURA_SEG (6)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .iniciar_vez       (iniciar_vez),
        .jogada_feita      (jogada_feita),
        .pausar            (pausar),
        .cancelar          (cancelar),
        .contando          (contando),
        .alerta            (alerta),
        .tempo_esgotado    (tempo_esgotado),
        .segundos_restantes(segundos_restantes),
        .db_estado         (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       ini;
        logic       jog;
        logic       pau;
        logic       can;
        logic       cont;
        logic       alr;
        logic       esg;
        logic [5:0] seg;
        logic [3:0] db;
    } vec_t;

    vec_t tab[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_step = 0;

    task automatic chk(input string nome, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d expected %0d", nome, idx, act, exp);
        end
    endtask

    task automatic add(input int n, input logic ini, input logic jog, input logic pau,
                       input logic can, input logic cont, input logic alr, input logic esg,
                       input int seg, input int db);
        vec_t v;
        v.ini = ini; v.jog = jog; v.pau = pau; v.can = can;
        v.cont = cont; v.alr = alr; v.esg = esg;
        v.seg = 6'(seg); v.db = 4'(db);
        for (int i = 0; i < n; i++) tab.push_back(v);
    endtask

    // Drive one vector, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        iniciar_vez  = v.ini;
        jogada_feita = v.jog;
        pausar       = v.pau;
        cancelar     = v.can;
        sb.push_back(v);
        @(posedge clock);
        #1;
        n_step++;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", n_step);
        end else begin
            e = sb.pop_front();
            chk("contando", n_step, int'(contando), int'(e.cont));
            chk("alerta", n_step, int'(alerta), int'(e.alr));
            chk("tempo_esgotado", n_step, int'(tempo_esgotado), int'(e.esg));
            chk("segundos_restantes", n_step, int'(segundos_restantes), int'(e.seg));
            chk("db_estado", n_step, int'(db_estado), int'(e.db));
        end
    endtask

    task automatic step_in(input logic ini, input logic jog, input logic pau, input logic can,
                           input logic cont, input logic alr, input logic esg,
                           input int seg, input int db);
        vec_t v;
        v.ini = ini; v.jog = jog; v.pau = pau; v.can = can;
        v.cont = cont; v.alr = alr; v.esg = esg;
        v.seg = 6'(seg); v.db = 4'(db);
        step(v);
    endtask

    task automatic chk_idle(input string nome);
        chk({nome, ".contando"}, n_step, int'(contando), 0);
        chk({nome, ".alerta"}, n_step, int'(alerta), 0);
        chk({nome, ".tempo_esgotado"}, n_step, int'(tempo_esgotado), 0);
        chk({nome, ".seg"}, n_step, int'(segundos_restantes), 3);
        chk({nome, ".db_estado"}, n_step, int'(db_estado), 0);
    endtask

    initial begin
        int seg_e, db_e;
        logic pau_e;

        //        n ini jog pau can cont alr esg seg db
        // full countdown to timeout
        add(1, 1, 0, 0, 0, 1, 0, 0, 3, 1);
        add(3, 0, 0, 0, 0, 1, 0, 0, 3, 1);
        add(4, 0, 0, 0, 0, 1, 0, 0, 2, 1);
        add(4, 0, 0, 0, 0, 1, 1, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 3);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // move made at edge 6; jogada in OCIOSO ignored
        add(1, 1, 0, 0, 0, 1, 0, 0, 3, 1);
        add(3, 0, 0, 0, 0, 1, 0, 0, 3, 1);
        add(2, 0, 0, 0, 0, 1, 0, 0, 2, 1);
        add(1, 0, 1, 0, 0, 0, 0, 0, 2, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 2, 0);
        add(4, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        // move coincident with the final tick, then a fresh turn
        add(1, 1, 0, 0, 0, 1, 0, 0, 3, 1);
        add(3, 0, 0, 0, 0, 1, 0, 0, 3, 1);
        add(4, 0, 0, 0, 0, 1, 0, 0, 2, 1);
        add(4, 0, 0, 0, 0, 1, 1, 0, 1, 2);
        add(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 0, 0, 3, 1);
        add(3, 0, 0, 0, 0, 1, 0, 0, 3, 1);
        add(4, 0, 0, 0, 0, 1, 0, 0, 2, 1);
        add(1, 0, 0, 0, 0, 1, 1, 0, 1, 2);
        // restart from ALERTA clears alerta; cancel during CONTANDO
        add(1, 1, 0, 0, 0, 1, 0, 0, 3, 1);
        add(3, 0, 0, 0, 0, 1, 0, 0, 3, 1);
        add(1, 0, 0, 0, 0, 1, 0, 0, 2, 1);
        add(1, 0, 0, 0, 1, 0, 0, 0, 3, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 3, 0);

        iniciar_vez  = 1'b0;
        jogada_feita = 1'b0;
        pausar       = 1'b0;
        cancelar     = 1'b0;
        reset        = 1'b0;

        // asynchronous reset, checked before any clock edge
        #1 reset = 1'b1;
        #2 chk_idle("reset_async");
        @(negedge clock);
        reset = 1'b0;

        foreach (tab[i]) step(tab[i]);

        // pause for 10 cycles from edge 2: every event shifts by 10 edges
        for (int e = 0; e < 24; e++) begin
            pau_e = (e >= 2 && e <= 11);
            seg_e = (e < 14) ? 3 : (e < 18) ? 2 : (e < 22) ? 1 : 0;
            db_e  = (e < 18) ? 1 : (e < 22) ? 2 : (e == 22) ? 3 : 0;
            step_in(e == 0, 1'b0, pau_e, 1'b0,
                    (e < 22) && !pau_e, (e >= 18 && e < 22), (e == 22), seg_e, db_e);
        end

        // reset asserted mid-cycle while in ALERTA
        for (int e = 0; e < 9; e++) begin
            seg_e = (e < 4) ? 3 : (e < 8) ? 2 : 1;
            step_in(e == 0, 1'b0, 1'b0, 1'b0, 1'b1, (e == 8), 1'b0, seg_e, (e == 8) ? 2 : 1);
        end
        #2 reset = 1'b1;
        #1 chk_idle("reset_alerta");
        @(negedge clock);
        reset = 1'b0;
        step_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
